// File: rtl/lifo_stack.sv
// Register-based LIFO stack with push/pop/peek and overflow/underflow flags.
// Latency: d_out valid one cycle after a successful pop or tos; empty/full/count decode combinationally.
// No backpressure: push on full and pop on empty are dropped and reported on ovf/udf (sticky with LIFO_STACK_STICKY_ERR_EN).
module lifo_stack #(
    parameter  int N     = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          tos,
    input  logic [N-1:0]  d_in,
    output logic [N-1:0]  d_out,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          ovf,
    output logic          udf
);

    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [N-1:0]  mem_q [DEPTH];
    logic [AW:0]   count_q, count_d;
    logic [N-1:0]  dout_q, dout_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic          is_empty, is_full;
    logic [AW:0]   top_ptr;
    logic [AW-1:0] top_idx, push_idx, wr_idx;
    logic          wr_en;
    logic          ovf_evt, udf_evt;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_FULL);
    assign top_ptr  = count_q - CNT_ONE;
    assign top_idx  = top_ptr[AW-1:0];
    assign push_idx = count_q[AW-1:0];

    always_comb begin
        count_d = count_q;
        dout_d  = dout_q;
        wr_en   = 1'b0;
        wr_idx  = push_idx;
        ovf_evt = 1'b0;
        udf_evt = 1'b0;
        if (pop) begin
            if (!is_empty) begin
                dout_d = mem_q[top_idx];
                if (push) begin
                    // Simultaneous push/pop swaps the top entry in place.
                    wr_en  = 1'b1;
                    wr_idx = top_idx;
                end else begin
                    count_d = top_ptr;
                end
            end else begin
                udf_evt = 1'b1;
                if (push) begin
                    wr_en   = 1'b1;
                    wr_idx  = '0;
                    count_d = CNT_ONE;
                end
            end
        end else begin
            // Peek reads the pre-push top, so it is resolved before the push below.
            if (tos && !is_empty) begin
                dout_d = mem_q[top_idx];
            end
            if (push) begin
                if (is_full) begin
                    ovf_evt = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    count_d = count_q + CNT_ONE;
                end
            end
        end
`ifdef LIFO_STACK_STICKY_ERR_EN
        ovf_d = ovf_q | ovf_evt;
        udf_d = udf_q | udf_evt;
`else
        ovf_d = ovf_evt;
        udf_d = udf_evt;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is deliberately not reset; entries above count are never read.
    always_ff @(posedge clk) begin
        if (wr_en && rst) begin
            mem_q[wr_idx] <= d_in;
        end
    end

    assign d_out = dout_q;
    assign count = count_q;
    assign empty = is_empty;
    assign full  = is_full;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

endmodule
